// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI master that shifts out 10-bit command frames and optionally reads back a byte
module spi_master #(
  parameter int RD_GAP = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {IDLE, SEL, SHIFT, WAIT, RECV, END} state_t;

  localparam logic [3:0] GAP_LOAD = (RD_GAP > 0) ? 4'(RD_GAP - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  shift_q, shift_d;
  logic [7:0]  rx_q, rx_d;
  logic        rd_q, rd_d;
  logic        cmd_ready_d, rsp_valid_d, busy_d, ss_n_d, mosi_d;
  logic [7:0]  rsp_data_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rx_d        = rx_q;
    rd_d        = rd_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data;
    ss_n_d      = SS_n;
    mosi_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d = SEL;
          shift_d = cmd_data;
          rd_d    = (cmd_data[9:8] == 2'b11);
          mosi_d  = cmd_data[9];
          ss_n_d  = 1'b0;
          cnt_d   = 4'd0;
        end
      end
      SEL: begin
        state_d = SHIFT;
        cnt_d   = 4'd9;
        mosi_d  = shift_q[9];
        shift_d = {shift_q[8:0], 1'b0};
      end
      SHIFT: begin
        if (cnt_q == 4'd0) begin
          if (!rd_q) begin
            state_d = END;
            ss_n_d  = 1'b1;
            cnt_d   = 4'd0;
          end else if (RD_GAP == 0) begin
            state_d = RECV;
            cnt_d   = 4'd7;
          end else begin
            state_d = WAIT;
            cnt_d   = GAP_LOAD;
          end
        end else begin
          cnt_d   = cnt_q - 4'd1;
          mosi_d  = shift_q[9];
          shift_d = {shift_q[8:0], 1'b0};
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RECV;
          cnt_d   = 4'd7;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RECV: begin
        // MISO is sampled at the edge closing each RECV cycle
        rx_d = {rx_q[6:0], MISO};
        if (cnt_q == 4'd0) begin
          state_d     = END;
          ss_n_d      = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_data_d  = {rx_q[6:0], MISO};
          cnt_d       = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      END: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = IDLE;
        ss_n_d  = 1'b1;
        cnt_d   = 4'd0;
      end
    endcase
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      shift_q   <= 10'd0;
      rx_q      <= 8'd0;
      rd_q      <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      busy      <= 1'b0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      rx_q      <= rx_d;
      rd_q      <= rd_d;
      cmd_ready <= cmd_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      busy      <= busy_d;
      SS_n      <= ss_n_d;
      MOSI      <= mosi_d;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - scoreboard bench for spi_master (RD_GAP=2 main instance, RD_GAP=0 side instance)
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, rsp_valid, busy, SS_n, MOSI, MISO;
  logic [9:0] cmd_data;
  logic [7:0] rsp_data;

  logic       c0_valid, c0_ready, rsp_valid0, busy0, SS_n0, MOSI0, MISO0;
  logic [9:0] c0_data;
  logic [7:0] rsp_data0;

  always #5 clk = ~clk;

  spi_master #(.RD_GAP(2)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  spi_master #(.RD_GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(c0_valid), .cmd_ready(c0_ready),
    .cmd_data(c0_data), .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .busy(busy0),
    .SS_n(SS_n0), .MOSI(MOSI0), .MISO(MISO0)
  );

  typedef struct {
    logic [9:0] data;
    int         low_len;
    bit         partial;
  } frame_t;

  frame_t     exp_frames[$];
  logic [7:0] exp_rsp[$];
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave models: drive the reply byte during the receive window, 1s elsewhere while selected
  logic [7:0] slave_byte = 8'h00, slave_byte0 = 8'h00;
  int sk = 0, sk0 = 0;
  bit sk_act = 0, sk0_act = 0;

  always @(posedge clk) begin
    #1;
    if (SS_n !== 1'b0) begin
      sk_act = 0;
      MISO = 1'b0;
    end else begin
      sk = sk_act ? sk + 1 : 0;
      sk_act = 1;
      MISO = (sk >= 13 && sk <= 20) ? slave_byte[20 - sk] : 1'b1;
    end
    if (SS_n0 !== 1'b0) begin
      sk0_act = 0;
      MISO0 = 1'b0;
    end else begin
      sk0 = sk0_act ? sk0 + 1 : 0;
      sk0_act = 1;
      MISO0 = (sk0 >= 11 && sk0 <= 18) ? slave_byte0[18 - sk0] : 1'b1;
    end
  end

  // Monitor: reconstructs each frame from SS_n/MOSI and checks responses
  logic       prev_ss = 1'b1;
  int         low_k = 0, high_run = 0;
  bit         seen_frame = 0;
  logic [9:0] bits;
  logic       sel_bit;

  always @(negedge clk) begin
    frame_t     f;
    logic [7:0] e;
    if (rsp_valid === 1'b1) begin
      if (exp_rsp.size() == 0) chk("unexpected_rsp_valid", 1, 0);
      else begin
        e = exp_rsp.pop_front();
        chk("rsp_data", rsp_data, e);
        chk("rsp_in_end_cycle", prev_ss, 0);
      end
    end
    if (SS_n === 1'b0) begin
      if (prev_ss !== 1'b0) begin
        if (seen_frame) chk("ss_high_gap_ge2", high_run >= 2, 1);
        seen_frame = 1;
        low_k = 0;
        sel_bit = MOSI;
        bits = 10'd0;
      end else begin
        low_k++;
      end
      if (low_k >= 1 && low_k <= 10) bits[10 - low_k] = MOSI;
    end else begin
      if (prev_ss === 1'b0) begin
        if (exp_frames.size() == 0) chk("unexpected_frame", 1, 0);
        else begin
          f = exp_frames.pop_front();
          chk("sel_mosi", sel_bit, f.data[9]);
          chk("mosi_bits", bits, f.data);
          if (!f.partial) chk("ss_low_len", low_k + 1, f.low_len);
        end
        high_run = 1;
      end else begin
        high_run++;
      end
    end
    prev_ss = SS_n;
  end

  task automatic wait_ready();
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("cmd_ready_timeout", 0, 1);
  endtask

  task automatic send(input logic [9:0] d, input int low_len, input logic [7:0] rsp, input bit is_rd);
    frame_t f;
    wait_ready();
    f.data = d;
    f.low_len = low_len;
    f.partial = 0;
    exp_frames.push_back(f);
    if (is_rd) exp_rsp.push_back(rsp);
    cmd_valid = 1'b1;
    cmd_data = d;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    frame_t f;
    int n;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_data = 10'd0;
    c0_valid = 1'b0;
    c0_data = 10'd0;
    repeat (3) @(negedge clk);
    chk("rst_ss_n", SS_n, 1);
    chk("rst_mosi", MOSI, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    send(10'h0A5, 11, 8'h00, 0);

    // Busy ignore: pulse a new command at T+5
    send(10'h0A5, 11, 8'h00, 0);
    repeat (4) @(negedge clk);
    chk("busy_mid_frame", busy, 1);
    chk("cmd_ready_mid_frame", cmd_ready, 0);
    cmd_valid = 1'b1;
    cmd_data = 10'h2AA;
    @(negedge clk);
    cmd_valid = 1'b0;

    send(10'h15A, 11, 8'h00, 0);
    send(10'h2C3, 11, 8'h00, 0);
    slave_byte = 8'h3C;
    send(10'h300, 21, 8'h3C, 1);
    wait_ready();
    slave_byte = 8'hA5;
    send(10'h3E7, 21, 8'hA5, 1);

    // Back-to-back with cmd_valid held high; data changes mid-frame
    wait_ready();
    f.data = 10'h012; f.low_len = 11; f.partial = 0;
    exp_frames.push_back(f);
    f.data = 10'h1FF;
    exp_frames.push_back(f);
    cmd_valid = 1'b1;
    cmd_data = 10'h012;
    @(posedge clk);
    @(negedge clk);
    cmd_data = 10'h1FF;
    n = 1;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_accept_cycle", n, 13);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;

    // Reset abort at T+16 of a read-data frame
    wait_ready();
    slave_byte = 8'h3C;
    f.data = 10'h300; f.low_len = 0; f.partial = 1;
    exp_frames.push_back(f);
    cmd_valid = 1'b1;
    cmd_data = 10'h300;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    cmd_valid = 1'b1;
    cmd_data = 10'h0A5;
    @(negedge clk);
    chk("abort_ss_n", SS_n, 1);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_rsp_data", rsp_data, 8'h00);
    chk("abort_busy", busy, 0);
    rst_n = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("ignore_in_reset_busy", busy, 0);
    slave_byte = 8'h81;
    send(10'h3C1, 21, 8'h81, 1);
    wait_ready();

    // RD_GAP=0 instance: response lands at T+20
    n = 0;
    while (c0_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    slave_byte0 = 8'hC3;
    c0_valid = 1'b1;
    c0_data = 10'h35A;
    @(posedge clk);
    @(negedge clk);
    c0_valid = 1'b0;
    n = 1;
    while (rsp_valid0 !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("gap0_rsp_cycle", n, 20);
    chk("gap0_rsp_data", rsp_data0, 8'hC3);
    chk("gap0_ss_n_end", SS_n0, 1);
    @(negedge clk);
    chk("gap0_rsp_pulse", rsp_valid0, 0);

    repeat (4) @(negedge clk);
    chk("frames_left", exp_frames.size(), 0);
    chk("rsp_left", exp_rsp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
